// File: rtl/legv8_pkg.sv
// LEGv8 decode-stage types: opcode constants, ALUOp encodings,
// control bundle and the ID/EX register layout.
package legv8_pkg;

  localparam logic [10:0] OP_ADD  = 11'b10001011000;
  localparam logic [10:0] OP_SUB  = 11'b11001011000;
  localparam logic [10:0] OP_AND  = 11'b10001010000;
  localparam logic [10:0] OP_ORR  = 11'b10101010000;
  localparam logic [10:0] OP_LDUR = 11'b11111000010;
  localparam logic [10:0] OP_STUR = 11'b11111000000;
  localparam logic [7:0]  OP_CBZ  = 8'b10110100;

  typedef enum logic [1:0] {
    ALU_MEM   = 2'b00,
    ALU_CBZ   = 2'b01,
    ALU_RTYPE = 2'b10
  } alu_op_e;

  typedef enum logic [1:0] {
    IMM_NONE = 2'b00,
    IMM_D9   = 2'b01,
    IMM_CB19 = 2'b10
  } imm_sel_e;

  typedef struct packed {
    logic    reg_write;
    logic    mem_read;
    logic    mem_write;
    logic    branch;
    logic    alu_src;
    alu_op_e alu_op;
  } ctrl_t;

  typedef struct packed {
    logic     use_rn;
    logic     use_rm;
    logic     rm_is_rt;
    logic     writes_rt;
    imm_sel_e imm_sel;
  } fields_t;

  typedef struct packed {
    logic        valid;
    ctrl_t       ctrl;
    logic [4:0]  read1;
    logic [4:0]  read2;
    logic [4:0]  write_reg;
    logic [10:0] opcode;
    logic [63:0] imm;
    logic [63:0] pc;
    logic        illegal;
  } id_ex_t;

  function automatic logic [63:0] decode_imm(
    logic [31:0] insn,
    imm_sel_e    sel
  );
    logic [63:0] v;
    v = '0;
    unique case (sel)
      IMM_D9:   v = {{55{insn[20]}}, insn[20:12]};
      IMM_CB19: v = {{45{insn[23]}}, insn[23:5]};
      default:  v = '0;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/id_stage_if.sv
// Fetch-side and ID/EX-side signals of the decode stage.
// master = surrounding pipeline, slave = id_stage.
interface id_stage_if;
  logic        in_valid;
  logic [31:0] instruction;
  logic [63:0] pc_in;
  logic        stall;
  logic        flush;
  logic        hold_upstream;
  logic        out_valid;
  logic [4:0]  Read1;
  logic [4:0]  Read2;
  logic [4:0]  WriteReg;
  logic        RegWrite;
  logic        MemRead;
  logic        MemWrite;
  logic        Branch;
  logic        ALUSrc;
  logic [1:0]  ALUOp;
  logic [10:0] Opcode;
  logic [63:0] imm;
  logic [63:0] pc_out;
  logic        illegal;

  modport master (
    output in_valid, instruction, pc_in,
    output stall, flush,
    input  hold_upstream, out_valid,
    input  Read1, Read2, WriteReg,
    input  RegWrite, MemRead, MemWrite,
    input  Branch, ALUSrc, ALUOp,
    input  Opcode, imm, pc_out, illegal
  );

  modport slave (
    input  in_valid, instruction, pc_in,
    input  stall, flush,
    output hold_upstream, out_valid,
    output Read1, Read2, WriteReg,
    output RegWrite, MemRead, MemWrite,
    output Branch, ALUSrc, ALUOp,
    output Opcode, imm, pc_out, illegal
  );
endinterface

// File: rtl/legv8_main_control.sv
// Combinational main control: opcode field to control bundle,
// operand-field usage and an illegal flag.
module legv8_main_control
  import legv8_pkg::*;
(
  input  logic [10:0] opcode,
  output ctrl_t       ctrl,
  output fields_t     fields,
  output logic        illegal
);

  logic is_r;
  logic is_ldur;
  logic is_stur;
  logic is_cbz;

  assign is_r = (opcode == OP_ADD) || (opcode == OP_SUB) ||
                (opcode == OP_AND) || (opcode == OP_ORR);
  assign is_ldur = (opcode == OP_LDUR);
  assign is_stur = (opcode == OP_STUR);
  assign is_cbz  = (opcode[10:3] == OP_CBZ);

  always_comb begin
    ctrl    = '0;
    fields  = '0;
    illegal = 1'b0;
    unique case (1'b1)
      is_r: begin
        ctrl.reg_write   = 1'b1;
        ctrl.alu_op      = ALU_RTYPE;
        fields.use_rn    = 1'b1;
        fields.use_rm    = 1'b1;
        fields.writes_rt = 1'b1;
      end
      is_ldur: begin
        ctrl.reg_write   = 1'b1;
        ctrl.mem_read    = 1'b1;
        ctrl.alu_src     = 1'b1;
        ctrl.alu_op      = ALU_MEM;
        fields.use_rn    = 1'b1;
        fields.writes_rt = 1'b1;
        fields.imm_sel   = IMM_D9;
      end
      is_stur: begin
        ctrl.mem_write  = 1'b1;
        ctrl.alu_src    = 1'b1;
        ctrl.alu_op     = ALU_MEM;
        fields.use_rn   = 1'b1;
        fields.use_rm   = 1'b1;
        fields.rm_is_rt = 1'b1;
        fields.imm_sel  = IMM_D9;
      end
      is_cbz: begin
        ctrl.branch     = 1'b1;
        ctrl.alu_op     = ALU_CBZ;
        fields.use_rm   = 1'b1;
        fields.rm_is_rt = 1'b1;
        fields.imm_sel  = IMM_CB19;
      end
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/id_stage.sv
// LEGv8 instruction-decode stage: decode, load-use interlock,
// stall/flush priority and the registered ID/EX boundary.
module id_stage
  import legv8_pkg::*;
(
  input logic       clock,
  input logic       reset_n,
  id_stage_if.slave bus
);

  ctrl_t   ctrl;
  fields_t fld;
  logic    dec_ill;
  logic    hazard;
  logic [4:0] rn;
  logic [4:0] rt;
  logic [4:0] rm;
  id_ex_t  q;
  id_ex_t  nxt;
  id_ex_t  load;

  legv8_main_control u_ctrl (
    .opcode  (bus.instruction[31:21]),
    .ctrl    (ctrl),
    .fields  (fld),
    .illegal (dec_ill)
  );

  assign rn = bus.instruction[9:5];
  assign rt = bus.instruction[4:0];
  assign rm = fld.rm_is_rt ? rt
                           : bus.instruction[20:16];

  // X31 is XZR, so a load into it never creates a dependency
  assign hazard = q.valid && q.ctrl.mem_read &&
                  (q.write_reg != 5'd31) &&
                  bus.in_valid && !dec_ill &&
                  ((fld.use_rn && rn == q.write_reg) ||
                   (fld.use_rm && rm == q.write_reg));

  assign bus.hold_upstream = bus.stall | hazard;

  always_comb begin
    load           = '0;
    load.valid     = 1'b1;
    load.ctrl      = ctrl;
    load.read1     = fld.use_rn ? rn : 5'd0;
    load.read2     = fld.use_rm ? rm : 5'd0;
    load.write_reg = fld.writes_rt ? rt : 5'd0;
    load.opcode    = bus.instruction[31:21];
    load.imm       = decode_imm(bus.instruction,
                                fld.imm_sel);
    load.pc        = bus.pc_in;
  end

  always_comb begin
    nxt = '0;
    if (bus.flush) begin
      nxt = '0;
    end else if (bus.stall) begin
      nxt         = q;
      nxt.illegal = 1'b0;
    end else if (hazard || !bus.in_valid) begin
      nxt = '0;
    end else if (dec_ill) begin
      nxt         = '0;
      nxt.illegal = 1'b1;
    end else begin
      nxt = load;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) q <= '0;
    else          q <= nxt;
  end

  assign bus.out_valid = q.valid;
  assign bus.Read1     = q.read1;
  assign bus.Read2     = q.read2;
  assign bus.WriteReg  = q.write_reg;
  assign bus.RegWrite  = q.ctrl.reg_write;
  assign bus.MemRead   = q.ctrl.mem_read;
  assign bus.MemWrite  = q.ctrl.mem_write;
  assign bus.Branch    = q.ctrl.branch;
  assign bus.ALUSrc    = q.ctrl.alu_src;
  assign bus.ALUOp     = q.ctrl.alu_op;
  assign bus.Opcode    = q.opcode;
  assign bus.imm       = q.imm;
  assign bus.pc_out    = q.pc;
  assign bus.illegal   = q.illegal;

endmodule

// File: tb/tb_id_stage.sv
// Self-checking bench for id_stage: directed cases plus random
// stimulus against a behavioural decode/hazard model.
module tb_id_stage;

  logic clock;
  logic reset_n;
  int   checks;
  int   failures;

  id_stage_if bus ();

  id_stage dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct packed {
    bit        v;
    bit        rw;
    bit        mr;
    bit        mw;
    bit        br;
    bit        as_;
    bit [1:0]  op;
    bit [4:0]  r1;
    bit [4:0]  r2;
    bit [4:0]  wr;
    bit [10:0] opc;
    bit [63:0] imm;
    bit [63:0] pc;
    bit        ill;
    bit        legal;
    bit        rd1;
    bit        rd2;
    bit        cwr;
  } exp_t;

  exp_t m = '0;
  exp_t dm;
  exp_t dc;
  bit   hm;
  bit   hc;

  function automatic exp_t dec(logic [31:0] i,
                               logic [63:0] pc);
    exp_t e;
    e       = '0;
    e.v     = 1'b1;
    e.legal = 1'b1;
    e.opc   = i[31:21];
    e.pc    = pc;
    case (i[31:21])
      11'h458, 11'h658, 11'h450, 11'h550: begin
        e.r1 = i[9:5];  e.r2 = i[20:16]; e.wr = i[4:0];
        e.rd1 = 1; e.rd2 = 1; e.cwr = 1;
        e.rw = 1; e.op = 2'd2;
      end
      11'h7C2: begin
        e.r1 = i[9:5]; e.wr = i[4:0];
        e.rd1 = 1; e.cwr = 1;
        e.rw = 1; e.mr = 1; e.as_ = 1; e.op = 2'd0;
        e.imm = 64'($signed(i[20:12]));
      end
      11'h7C0: begin
        e.r1 = i[9:5]; e.r2 = i[4:0];
        e.rd1 = 1; e.rd2 = 1;
        e.mw = 1; e.as_ = 1; e.op = 2'd0;
        e.imm = 64'($signed(i[20:12]));
      end
      default: begin
        if (i[31:24] == 8'hB4) begin
          e.r2 = i[4:0]; e.rd2 = 1;
          e.br = 1; e.op = 2'd1;
          e.imm = 64'($signed(i[23:5]));
        end else begin
          e = '0;
        end
      end
    endcase
    return e;
  endfunction

  // load-use: previous entry loads a real register the new one reads
  function automatic bit haz(exp_t st, exp_t d, bit iv);
    return st.v && st.mr && st.wr != 5'd31 && iv &&
           d.legal &&
           ((d.rd1 && d.r1 == st.wr) ||
            (d.rd2 && d.r2 == st.wr));
  endfunction

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h t=%0t",
               nm, act, exp, $time);
    end
  endtask

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      m <= '0;
    end else begin
      dm = dec(bus.instruction, bus.pc_in);
      hm = haz(m, dm, bus.in_valid);
      if (bus.flush)                 m <= '0;
      else if (bus.stall)            m.ill <= 1'b0;
      else if (hm || !bus.in_valid)  m <= '0;
      else if (!dm.legal) begin
        m     <= '0;
        m.ill <= 1'b1;
      end else                       m <= dm;
    end
  end

  always @(negedge clock) begin
    dc = dec(bus.instruction, bus.pc_in);
    hc = bus.stall || haz(m, dc, bus.in_valid);
    chk("m_hold", bus.hold_upstream, hc);
    chk("m_valid", bus.out_valid, m.v);
    chk("m_ctrl",
        {bus.RegWrite, bus.MemRead, bus.MemWrite,
         bus.Branch, bus.ALUSrc, bus.ALUOp},
        {m.rw, m.mr, m.mw, m.br, m.as_, m.op});
    chk("m_illegal", bus.illegal, m.ill);
    chk("m_opcode", bus.Opcode, m.opc);
    chk("m_imm", bus.imm, m.imm);
    if (!m.v || m.rd1) chk("m_read1", bus.Read1, m.r1);
    if (!m.v || m.rd2) chk("m_read2", bus.Read2, m.r2);
    if (!m.v || m.cwr) chk("m_wreg", bus.WriteReg, m.wr);
    if (m.v) chk("m_pc", bus.pc_out, m.pc);
  end

  function automatic logic [31:0] rand_insn();
    logic [10:0] rops [4];
    logic [4:0]  a;
    logic [4:0]  b;
    logic [4:0]  c;
    int          k;
    rops = '{11'h458, 11'h658, 11'h450, 11'h550};
    a = ($urandom_range(0, 9) == 0) ? 5'd31
                                    : 5'($urandom_range(0, 3));
    b = 5'($urandom_range(0, 3));
    c = 5'($urandom_range(0, 3));
    k = $urandom_range(0, 8);
    case (k)
      0, 1, 2, 3:
        return {rops[k], b, 6'($urandom), c, a};
      4, 5:
        return {11'h7C2, 9'($urandom), 2'b00, c, a};
      6:
        return {11'h7C0, 9'($urandom), 2'b00, c, a};
      7:
        return {8'hB4, 19'($urandom), a};
      default:
        return 32'($urandom);
    endcase
  endfunction

  logic [31:0] stur_i;
  bit          h;

  initial begin
    checks   = 0;
    failures = 0;
    reset_n  = 1'b1;
    bus.in_valid    = 1'b0;
    bus.instruction = '0;
    bus.pc_in       = '0;
    bus.stall       = 1'b0;
    bus.flush       = 1'b0;
    #2 reset_n = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    chk("rst_valid", bus.out_valid, 0);
    chk("rst_hold", bus.hold_upstream, 0);
    chk("rst_illegal", bus.illegal, 0);
    chk("rst_regwrite", bus.RegWrite, 0);
    chk("rst_pc", bus.pc_out, 0);

    reset_n         = 1'b1;
    bus.in_valid    = 1'b1;
    bus.instruction = 32'h8B020023;
    bus.pc_in       = 64'h100;
    @(posedge clock); #1;
    chk("add_valid", bus.out_valid, 1);
    chk("add_read1", bus.Read1, 1);
    chk("add_read2", bus.Read2, 2);
    chk("add_wreg", bus.WriteReg, 3);
    chk("add_regwrite", bus.RegWrite, 1);
    chk("add_aluop", bus.ALUOp, 2'b10);
    chk("add_opcode", bus.Opcode, 11'h458);

    bus.instruction = 32'hF8408025;
    bus.pc_in       = 64'h104;
    @(posedge clock); #1;
    bus.instruction = 32'h8B0200A6;
    bus.pc_in       = 64'h108;
    #1;
    chk("ldur_memread", bus.MemRead, 1);
    chk("ldur_imm", bus.imm, 64'd8);
    chk("lu_hold", bus.hold_upstream, 1);
    @(posedge clock); #1;
    chk("lu_bubble", bus.out_valid, 0);
    chk("lu_hold_clr", bus.hold_upstream, 0);
    @(posedge clock); #1;
    chk("lu_add_valid", bus.out_valid, 1);
    chk("lu_add_read1", bus.Read1, 5);
    chk("lu_add_wreg", bus.WriteReg, 6);

    bus.instruction = 32'hB4FFFFC4;
    bus.pc_in       = 64'h10C;
    @(posedge clock); #1;
    chk("cbz_read2", bus.Read2, 4);
    chk("cbz_branch", bus.Branch, 1);
    chk("cbz_aluop", bus.ALUOp, 2'b01);
    chk("cbz_imm", bus.imm, 64'hFFFF_FFFF_FFFF_FFFE);
    chk("cbz_regwrite", bus.RegWrite, 0);

    stur_i          = {11'h7C0, 9'd16, 2'b00, 5'd2, 5'd7};
    bus.instruction = stur_i;
    bus.pc_in       = 64'h110;
    @(posedge clock); #1;
    chk("stur_memwrite", bus.MemWrite, 1);
    chk("stur_read1", bus.Read1, 2);
    chk("stur_read2", bus.Read2, 7);
    chk("stur_imm", bus.imm, 64'd16);
    bus.stall       = 1'b1;
    bus.instruction = 32'h8B020023;
    #1;
    chk("stall_hold", bus.hold_upstream, 1);
    repeat (3) begin
      @(posedge clock); #1;
      chk("stall_valid", bus.out_valid, 1);
      chk("stall_memwrite", bus.MemWrite, 1);
      chk("stall_read2", bus.Read2, 7);
      chk("stall_pc", bus.pc_out, 64'h110);
      chk("stall_hold", bus.hold_upstream, 1);
    end
    bus.flush = 1'b1;
    @(posedge clock); #1;
    chk("flush_valid", bus.out_valid, 0);
    chk("flush_memwrite", bus.MemWrite, 0);
    bus.flush = 1'b0;
    bus.stall = 1'b0;

    bus.instruction = 32'h0;
    @(posedge clock); #1;
    chk("ill_pulse", bus.illegal, 1);
    chk("ill_valid", bus.out_valid, 0);
    bus.in_valid = 1'b0;
    @(posedge clock); #1;
    chk("ill_clear", bus.illegal, 0);

    bus.in_valid    = 1'b1;
    bus.instruction = 32'h8B020023;
    @(posedge clock); #1;
    chk("pre_rst_valid", bus.out_valid, 1);
    #1 reset_n = 1'b0;
    #1;
    chk("arst_valid", bus.out_valid, 0);
    chk("arst_regwrite", bus.RegWrite, 0);
    chk("arst_read1", bus.Read1, 0);
    #4 reset_n = 1'b1;
    @(posedge clock); #1;
    chk("post_rst_valid", bus.out_valid, 1);
    chk("post_rst_read1", bus.Read1, 1);
    chk("post_rst_wreg", bus.WriteReg, 3);

    for (int n = 0; n < 3000; n++) begin
      @(negedge clock);
      h = bus.hold_upstream;
      @(posedge clock); #1;
      if (!h) begin
        bus.in_valid    = ($urandom_range(0, 9) != 0);
        bus.instruction = rand_insn();
        bus.pc_in       = {$urandom, $urandom};
      end
      bus.stall = ($urandom_range(0, 7) == 0);
      bus.flush = ($urandom_range(0, 11) == 0);
    end
    @(negedge clock);
    @(negedge clock);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
